regfile_write_buffer: RTL and testbench
=======================================

Name: regfile_write_buffer

Overview:
- Write-request buffer sitting directly upstream of the 32x4 register file BEL write port (W_ADR/D/W_en).
- Queues (address, data) write requests from the switch matrix through a valid/ready handshake. Drains one request per UserCLK into the register file.
- Optionally coalesces back-to-back writes to the same address.
- Decouples bursty fabric-side writers from the single-write-per-cycle register file.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16
- ADR_W, 5, write address width (matches 32-entry register file)
- DATA_W, 4, write data width
- NoConfigBits, 2, configuration bits consumed

Ports:
- UserCLK  in  1  user clock, rising edge; shared with the register file
- Reset  in  1  asynchronous, active-high reset
- IN_valid  in  1  write request valid
- IN_ready  out  1  buffer can accept request this cycle
- IN_ADR  in  ADR_W  request address
- IN_D  in  DATA_W  request data
- stall  in  1  holds drain when high
- W_en  out  1  register file write enable
- W_ADR  out  ADR_W  register file write address
- D  out  DATA_W  register file write data
- FULL  out  1  count == DEPTH
- EMPTY  out  1  count == 0
- COUNT  out  log2(DEPTH)+1  occupancy
- ConfigBits  in  NoConfigBits  [0] registered output stage, [1] write combining

Behaviour:
- Storage: circular buffer, rd_ptr/wr_ptr wrap modulo DEPTH, separate count register.
- Reset (async, immediate):
  - ptrs = 0, count = 0, EMPTY = 1, FULL = 0, COUNT = 0.
  - W_en = 0, W_ADR = 0, D = 0.
  - IN_ready forced 0 while Reset high; 1 on the first cycle after release.
  - Queued entries are discarded. Storage contents are don't-care.
- Push: IN_valid && IN_ready at a rising edge writes {IN_ADR, IN_D} at wr_ptr, then wr_ptr++ and count++.
- Pop condition: !EMPTY && !stall.
  - Pop advances rd_ptr and count--.
  - Push and pop on the same edge leave count unchanged.
- ConfigBits[0]=0 (direct output):
  - W_en = pop condition (combinational).
  - W_ADR/D = head entry; 0 when EMPTY.
  - Latency: request accepted at edge k into an empty buffer gives W_en high during cycle k+1 (stall low).
- ConfigBits[0]=1 (registered output):
  - W_en/W_ADR/D are registers loaded at the pop edge: W_en <= pop, data <= head.
  - Latency: accept at edge k gives W_en high during cycle k+2.
  - W_ADR/D hold their last value when W_en is 0.
- IN_ready = !FULL || combine_hit.
  - Push at FULL without a hit is impossible.
  - A pop at FULL does not raise IN_ready in the same cycle.
- Write combining (ConfigBits[1]=1):
  - combine_hit = !EMPTY && IN_ADR == newest entry address && newest entry not popped this edge (count > 1 || !pop).
  - On hit with IN_valid: overwrite newest entry data with IN_D; wr_ptr and count unchanged.
  - On hit where the newest entry is being popped: no combine; normal push.
  - ConfigBits[1]=0: combine_hit = 0.
- stall high: head held. In mode 1, W_en drops to 0 on the next edge. Pushes continue until FULL.
- ConfigBits assumed static during operation; a change mid-stream is undefined.

Optional Feature:
- Macro: REGFILE_WBUF_HAZARD_EN.
- Defined: adds input A_ADR[ADR_W-1:0] and output A_HIT[1].
  - A_HIT is combinational, 1 if any occupied queue entry has address == A_ADR.
  - In mode 1, the entry held in the output register with W_en=1 also counts.
  - Lets a reader detect that the register file value is stale.
  - A_HIT = 0 during Reset and when EMPTY with no pending output register write.
- Undefined: ports absent, no comparators.

Test Plan:
- Reset/idle: assert Reset mid-burst with count=3 → W_en=0, COUNT=0, EMPTY=1, IN_ready=0 immediately. IN_ready=1 the cycle after release; no stale entries drain.
- Direct mode, ConfigBits=00: push (ADR 5, D 0xA) at edge 0 → W_en=1, W_ADR=5, D=0xA in cycle 1, EMPTY=1 after edge 1.
- Fill/full: stall=1, push 4 requests (ADR 1..4) → FULL=1, IN_ready=0, 5th request not accepted. Release stall → writes drain in order ADR 1,2,3,4 on consecutive cycles.
- Registered mode, ConfigBits=01: single push at edge 0 → W_en high only in cycle 2 with the pushed values. Continuous push plus drain sustains 1 write/cycle with COUNT stable.
- Combining, ConfigBits=10, stall=1: push (7, 0x1) then (7, 0x2) then (8, 0x3) → COUNT=2. Drain writes (7, 0x2) then (8, 0x3). At FULL with newest ADR 9, push ADR 9 is accepted (IN_ready=1).
- Hazard (REGFILE_WBUF_HAZARD_EN): queue holds ADR 12, A_ADR=12 → A_HIT=1. A_ADR=13 → A_HIT=0. After ADR 12 drains → A_HIT=0.

Source files
------------

// File: rtl/regfile_write_buffer_if.sv
// -----------------------------------------------------------------------------
// regfile_write_buffer_if
//
// Purpose:
//   Request channel between a fabric-side writer and regfile_write_buffer.
//   Carries one (address, data) write request per accepted valid/ready
//   handshake.
//
// Signals:
//   IN_valid  writer has a request on IN_ADR/IN_D
//   IN_ready  buffer accepts the request at the next rising clock edge
//   IN_ADR    request address (ADR_W bits)
//   IN_D      request data    (DATA_W bits)
//
// Modports:
//   master    writer side (drives valid/address/data, observes ready)
//   slave     buffer side (observes valid/address/data, drives ready)
// -----------------------------------------------------------------------------
interface regfile_write_buffer_if #(
    parameter int ADR_W  = 5,
    parameter int DATA_W = 4
);
    logic              IN_valid;
    logic              IN_ready;
    logic [ADR_W-1:0]  IN_ADR;
    logic [DATA_W-1:0] IN_D;

    modport master (
        output IN_valid,
        output IN_ADR,
        output IN_D,
        input  IN_ready
    );

    modport slave (
        input  IN_valid,
        input  IN_ADR,
        input  IN_D,
        output IN_ready
    );
endinterface : regfile_write_buffer_if

// File: rtl/regfile_write_buffer.sv
// -----------------------------------------------------------------------------
// regfile_write_buffer
//
// Purpose:
//   Write-request buffer directly upstream of the 32x4 register file write
//   port (W_ADR / D / W_en). Requests arrive from the switch matrix through a
//   valid/ready handshake, are queued in a circular buffer and drained at one
//   write per UserCLK. Optionally, back-to-back writes to the same address
//   are coalesced into the newest queue entry.
//
// Parameters:
//   DEPTH         queue entries, power of two, 2..16
//   ADR_W         write address width
//   DATA_W        write data width
//   NoConfigBits  configuration bits consumed
//
// Ports:
//   UserCLK       rising-edge clock, shared with the register file
//   Reset         asynchronous, active-high reset
//   in_bus        request channel (IN_valid / IN_ready / IN_ADR / IN_D)
//   stall         holds the drain while high
//   W_en          register file write enable
//   W_ADR         register file write address
//   D             register file write data
//   FULL          occupancy == DEPTH
//   EMPTY         occupancy == 0
//   COUNT         occupancy
//   ConfigBits    [0] registered output stage, [1] write combining
//
// Optional feature (macro REGFILE_WBUF_HAZARD_EN):
//   A_ADR         address probed by a register file reader
//   A_HIT         a pending write (queued, or held in the output register
//                 with W_en high) targets A_ADR, so the register file copy
//                 of that address is stale
// -----------------------------------------------------------------------------
module regfile_write_buffer #(
    parameter int DEPTH        = 4,
    parameter int ADR_W        = 5,
    parameter int DATA_W       = 4,
    parameter int NoConfigBits = 2
) (
    input  logic                     UserCLK,
    input  logic                     Reset,
    regfile_write_buffer_if.slave    in_bus,
    input  logic                     stall,
    output logic                     W_en,
    output logic [ADR_W-1:0]         W_ADR,
    output logic [DATA_W-1:0]        D,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    input  logic [NoConfigBits-1:0]  ConfigBits
`ifdef REGFILE_WBUF_HAZARD_EN
    ,
    input  logic [ADR_W-1:0]         A_ADR,
    output logic                     A_HIT
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    // Registered output stage (used when ConfigBits[0] = 1)
    logic               r_w_en;
    logic [ADR_W-1:0]   r_w_adr;
    logic [DATA_W-1:0]  r_w_data;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_cfg_reg_out;
    logic               w_cfg_combine;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic [PTR_W-1:0]   w_newest_ptr;
    entry_t             w_head;
    entry_t             w_newest;
    logic               w_combine_hit;
    logic               w_accept;
    logic               w_push;
    logic               w_combine;

    assign w_cfg_reg_out = ConfigBits[0];
    assign w_cfg_combine = ConfigBits[1];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = !w_empty && !stall;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign w_newest_ptr = r_wr_ptr - PTR_W'(1);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_newest     = r_mem[w_newest_ptr];

    // A hit may only merge into the newest entry if that entry is still in
    // the queue after this edge; with a single entry being drained right
    // now, the request has to become a fresh entry instead.
    assign w_combine_hit = w_cfg_combine
                        && !w_empty
                        && (in_bus.IN_ADR == w_newest.adr)
                        && ((r_count > CNT_W'(1)) || !w_pop);

    // Ready is deliberately not widened by a same-cycle pop at FULL: this
    // keeps IN_ready off the stall path.
    assign in_bus.IN_ready = !Reset && (!w_full || w_combine_hit);

    assign w_accept  = in_bus.IN_valid && in_bus.IN_ready;
    assign w_combine = w_accept && w_combine_hit;
    assign w_push    = w_accept && !w_combine_hit;

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values regardless of block order.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; occupancy is tracked by
    // r_count, so stale contents are never observed and the array can map
    // onto plain flops or distributed RAM without a reset network.
    always_ff @(posedge UserCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{adr: in_bus.IN_ADR, data: in_bus.IN_D};
        end else if (w_combine) begin
            r_mem[w_newest_ptr].data <= in_bus.IN_D;
        end
    end

    // ------------------------------------------------------------------
    // Registered output stage: loaded on every edge, W_ADR/D only move on a
    // pop so they hold their last value while W_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            r_w_en   <= 1'b0;
            r_w_adr  <= '0;
            r_w_data <= '0;
        end else begin
            r_w_en <= w_pop;
            if (w_pop) begin
                r_w_adr  <= w_head.adr;
                r_w_data <= w_head.data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output selection
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first so
    // no path through the block leaves it unassigned (no latch inferred).
    always_comb begin
        W_en  = 1'b0;
        W_ADR = '0;
        D     = '0;
        if (w_cfg_reg_out) begin
            W_en  = r_w_en;
            W_ADR = r_w_adr;
            D     = r_w_data;
        end else begin
            W_en = w_pop;
            if (!w_empty) begin
                W_ADR = w_head.adr;
                D     = w_head.data;
            end
        end
    end

    assign FULL  = w_full;
    assign EMPTY = w_empty;
    assign COUNT = r_count;

`ifdef REGFILE_WBUF_HAZARD_EN
    // ------------------------------------------------------------------
    // Read-after-write hazard probe
    // ------------------------------------------------------------------
    // Slot i is occupied when its distance from the head (mod DEPTH) is
    // below the occupancy count.
    logic [PTR_W-1:0] w_slot_off;
    logic             w_queue_hit;
    logic             w_outreg_hit;

    always_comb begin
        w_queue_hit = 1'b0;
        w_slot_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_off = PTR_W'(i) - r_rd_ptr;
            if (({1'b0, w_slot_off} < r_count) && (r_mem[i].adr == A_ADR)) begin
                w_queue_hit = 1'b1;
            end
        end
    end

    // In registered mode the write sitting in the output stage has left the
    // queue but has not reached the register file yet.
    assign w_outreg_hit = w_cfg_reg_out && r_w_en && (r_w_adr == A_ADR);

    assign A_HIT = !Reset && (w_queue_hit || w_outreg_hit);
`endif

endmodule : regfile_write_buffer

// File: tb/tb_regfile_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_buffer
//
// Directed bench for regfile_write_buffer. Expected register file writes are
// queued when the corresponding request is driven and retired in order by a
// monitor that watches W_en on the falling clock edge. Directed checks cover
// reset, latency in both output modes, full/ready behaviour, and combining.
// The hazard probe section is built when REGFILE_WBUF_HAZARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_regfile_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADR_W  = 5;
    localparam int DATA_W = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                   UserCLK;
    logic                   Reset;
    logic                   stall;
    logic                   W_en;
    logic [ADR_W-1:0]       W_ADR;
    logic [DATA_W-1:0]      D;
    logic                   FULL;
    logic                   EMPTY;
    logic [CNT_W-1:0]       COUNT;
    logic [1:0]             ConfigBits;
`ifdef REGFILE_WBUF_HAZARD_EN
    logic [ADR_W-1:0]       A_ADR;
    logic                   A_HIT;
`endif

    regfile_write_buffer_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_buffer #(
        .DEPTH       (DEPTH),
        .ADR_W       (ADR_W),
        .DATA_W      (DATA_W),
        .NoConfigBits(2)
    ) dut (
        .UserCLK   (UserCLK),
        .Reset     (Reset),
        .in_bus    (bus),
        .stall     (stall),
        .W_en      (W_en),
        .W_ADR     (W_ADR),
        .D         (D),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .ConfigBits(ConfigBits)
`ifdef REGFILE_WBUF_HAZARD_EN
        ,
        .A_ADR     (A_ADR),
        .A_HIT     (A_HIT)
`endif
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    int checks = 0;
    int errors = 0;

    logic [ADR_W+DATA_W-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [ADR_W-1:0] adr,
                         input logic [DATA_W-1:0] data);
        bus.IN_valid = valid;
        bus.IN_ADR   = adr;
        bus.IN_D     = data;
    endtask

    task automatic expect_write(input logic [ADR_W-1:0] adr,
                                input logic [DATA_W-1:0] data);
        sb.push_back({adr, data});
    endtask

    task automatic do_reset(input logic [1:0] cfg);
        Reset      = 1'b1;
        ConfigBits = cfg;
        stall      = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        Reset = 1'b0;
        #1;
    endtask

    // Scoreboard monitor: every register file write must match the oldest
    // outstanding expectation.
    always @(negedge UserCLK) begin
        if (!Reset && W_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed=%0h expected=none", {W_ADR, D});
            end else begin
                check("write_order", {W_ADR, D}, sb.pop_front());
            end
        end
    end

    initial begin
        Reset      = 1'b1;
        stall      = 1'b0;
        ConfigBits = 2'b00;
        drive(1'b0, '0, '0);
`ifdef REGFILE_WBUF_HAZARD_EN
        A_ADR = '0;
`endif
        #2;
        // ---------------- reset state ----------------
        check("rst_ready", bus.IN_ready, 1'b0);
        check("rst_empty", EMPTY, 1'b1);
        check("rst_full",  FULL, 1'b0);
        check("rst_count", COUNT, 0);
        check("rst_wen",   W_en, 1'b0);
        check("rst_wadr",  W_ADR, 0);
        check("rst_d",     D, 0);
`ifdef REGFILE_WBUF_HAZARD_EN
        check("rst_ahit",  A_HIT, 1'b0);
`endif
        tick();
        Reset = 1'b0;
        #1;
        check("ready_after_release", bus.IN_ready, 1'b1);

        // ---------------- direct mode latency ----------------
        drive(1'b1, 5'd5, 4'hA);
        expect_write(5'd5, 4'hA);
        tick();                         // edge 0: accepted
        drive(1'b0, '0, '0);
        check("direct_wen_c1",  W_en, 1'b1);
        check("direct_wadr_c1", W_ADR, 5);
        check("direct_d_c1",    D, 4'hA);
        check("direct_cnt_c1",  COUNT, 1);
        tick();                         // edge 1: drained
        check("direct_empty_c2", EMPTY, 1'b1);
        check("direct_wen_c2",   W_en, 1'b0);
        check("direct_wadr_c2",  W_ADR, 0);

        // ---------------- fill to FULL under stall ----------------
        stall = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, ADR_W'(i), DATA_W'(i + 8));
            expect_write(ADR_W'(i), DATA_W'(i + 8));
            tick();
        end
        check("full_flag",  FULL, 1'b1);
        check("full_count", COUNT, DEPTH);
        check("full_wen",   W_en, 1'b0);
        drive(1'b1, 5'd5, 4'hF);        // fifth request must be refused
        #1;
        check("full_ready", bus.IN_ready, 1'b0);
        tick();
        check("full_no_accept", COUNT, DEPTH);
        drive(1'b0, '0, '0);
        stall = 1'b0;
        #1;
        check("drain_wen",          W_en, 1'b1);
        check("drain_first_adr",    W_ADR, 1);
        check("pop_at_full_ready",  bus.IN_ready, 1'b0);
        for (int i = 2; i <= DEPTH; i++) begin
            tick();
            check("drain_adr", W_ADR, i);
            check("drain_wen_cont", W_en, 1'b1);
        end
        tick();
        check("drain_done_empty", EMPTY, 1'b1);

        // ---------------- reset mid-burst ----------------
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADR_W'(20 + i), DATA_W'(i));
            tick();
        end
        check("burst_count", COUNT, 3);
        Reset = 1'b1;                   // asserted mid-cycle, IN_valid still high
        stall = 1'b0;
        #1;
        check("midrst_wen",   W_en, 1'b0);
        check("midrst_count", COUNT, 0);
        check("midrst_empty", EMPTY, 1'b1);
        check("midrst_ready", bus.IN_ready, 1'b0);
        tick();
        drive(1'b0, '0, '0);
        Reset = 1'b0;
        #1;
        check("midrst_ready_release", bus.IN_ready, 1'b1);
        tick();
        tick();
        check("midrst_no_stale", EMPTY, 1'b1);

        // ---------------- registered output mode ----------------
        do_reset(2'b01);
        drive(1'b1, 5'd3, 4'h6);
        expect_write(5'd3, 4'h6);
        tick();                         // edge 0
        drive(1'b0, '0, '0);
        check("reg_wen_c1",  W_en, 1'b0);
        check("reg_wadr_c1", W_ADR, 0);
        check("reg_cnt_c1",  COUNT, 1);
        tick();                         // edge 1
        check("reg_wen_c2",  W_en, 1'b1);
        check("reg_wadr_c2", W_ADR, 3);
        check("reg_d_c2",    D, 4'h6);
        check("reg_cnt_c2",  COUNT, 0);
        tick();                         // edge 2
        check("reg_wen_c3",  W_en, 1'b0);
        check("reg_hold_adr", W_ADR, 3);
        check("reg_hold_d",   D, 4'h6);

        // sustained one write per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ADR_W'(16 + i), DATA_W'(i));
            expect_write(ADR_W'(16 + i), DATA_W'(i));
            tick();
            if (i >= 1) begin
                check("stream_count", COUNT, 1);
                check("stream_wen",   W_en, 1'b1);
            end
        end
        drive(1'b0, '0, '0);
        tick();
        check("stream_tail_wen", W_en, 1'b1);
        check("stream_tail_cnt", COUNT, 0);
        tick();
        check("stream_idle_wen", W_en, 1'b0);

        // ---------------- write combining ----------------
        do_reset(2'b10);
        stall = 1'b1;
        drive(1'b1, 5'd7, 4'h1);
        tick();
        drive(1'b1, 5'd7, 4'h2);
        #1;
        check("comb_hit_ready", bus.IN_ready, 1'b1);
        tick();
        check("comb_count_hold", COUNT, 1);
        drive(1'b1, 5'd8, 4'h3);
        tick();
        check("comb_count", COUNT, 2);
        drive(1'b1, 5'd10, 4'h5);
        tick();
        drive(1'b1, 5'd9, 4'h6);
        tick();
        check("comb_full", FULL, 1'b1);
        drive(1'b0, 5'd10, 4'h0);       // not the newest address
        #1;
        check("comb_full_miss_ready", bus.IN_ready, 1'b0);
        drive(1'b1, 5'd9, 4'h7);        // newest address
        #1;
        check("comb_full_hit_ready", bus.IN_ready, 1'b1);
        tick();
        check("comb_full_count", COUNT, DEPTH);
        drive(1'b0, '0, '0);
        expect_write(5'd7, 4'h2);
        expect_write(5'd8, 4'h3);
        expect_write(5'd10, 4'h5);
        expect_write(5'd9, 4'h7);
        stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
        end
        check("comb_drained", EMPTY, 1'b1);

        // newest entry popped this edge: same address becomes a new entry
        drive(1'b1, 5'd4, 4'h1);
        expect_write(5'd4, 4'h1);
        tick();
        drive(1'b1, 5'd4, 4'h2);
        expect_write(5'd4, 4'h2);
        tick();
        drive(1'b0, '0, '0);
        check("comb_popping_count", COUNT, 1);
        tick();
        check("comb_popping_empty", EMPTY, 1'b1);

`ifdef REGFILE_WBUF_HAZARD_EN
        // ---------------- hazard probe ----------------
        do_reset(2'b00);
        stall = 1'b1;
        drive(1'b1, 5'd12, 4'h3);
        expect_write(5'd12, 4'h3);
        tick();
        drive(1'b0, '0, '0);
        A_ADR = 5'd12;
        #1;
        check("hazard_hit", A_HIT, 1'b1);
        A_ADR = 5'd13;
        #1;
        check("hazard_miss", A_HIT, 1'b0);
        A_ADR = 5'd12;
        stall = 1'b0;
        tick();
        check("hazard_after_drain", A_HIT, 1'b0);

        // registered mode: output-stage entry still counts
        do_reset(2'b01);
        drive(1'b1, 5'd12, 4'h4);
        expect_write(5'd12, 4'h4);
        tick();
        drive(1'b0, '0, '0);
        tick();
        check("hazard_outreg_hit", A_HIT, 1'b1);
        tick();
        check("hazard_outreg_clear", A_HIT, 1'b0);
`endif

        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_write_buffer
